// File: rtl/l1_mmu_arbiter.sv
// Round-robin arbiter sharing one MMU line-transfer port between the I and D L1 caches.
// One whole transaction is granted at a time; done and read data are routed back to the owner only.
module l1_mmu_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_read,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LINE_W-1:0] i_write_data,
  output logic              i_read_done,
  output logic              i_write_done,
  output logic [LINE_W-1:0] i_read_data,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_write_data,
  output logic              d_read_done,
  output logic              d_write_done,
  output logic [LINE_W-1:0] d_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_read_done,
  input  logic              mmu_write_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  cnt_i_txn,
  output logic [CNT_W-1:0]  cnt_d_txn,
  output logic [1:0]        dbg_state
);

  // Handshake: a cache request is a level held until its done pulse; the done pulse is
  // combinational from the matching MMU done while BUSY and lasts exactly that cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              i_want, d_want;
  logic              grant_valid, grant_d, accept;
  logic              win_read, win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [LINE_W-1:0] win_data;
  logic              rd_acc, wr_acc;

  assign i_want = i_req_read | i_req_write;
  assign d_want = d_req_read | d_req_write;

  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_d     = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (i_want | d_want) begin
          grant_valid = 1'b1;
          // On a tie the side that did not hold the last grant wins.
          grant_d     = d_want & (~i_want | ~owner);
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        accept = (mmu_req_read & mmu_read_done) | (mmu_req_write & mmu_write_done);
        if (accept) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign win_read  = grant_d ? d_req_read   : i_req_read;
  assign win_write = grant_d ? d_req_write  : i_req_write;
  assign win_addr  = grant_d ? d_req_addr   : i_req_addr;
  assign win_data  = grant_d ? d_write_data : i_write_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmu_req_read   <= 1'b0;
      mmu_req_write  <= 1'b0;
      mmu_req_addr   <= '0;
      mmu_write_data <= '0;
      owner          <= 1'b0;
    end else if (grant_valid) begin
      // A simultaneous read+write from one side issues only the read.
      mmu_req_read   <= win_read;
      mmu_req_write  <= win_write & ~win_read;
      mmu_req_addr   <= win_addr;
      mmu_write_data <= win_data;
      owner          <= grant_d;
    end else if (accept) begin
      mmu_req_read   <= 1'b0;
      mmu_req_write  <= 1'b0;
      mmu_req_addr   <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_i_txn <= '0;
      cnt_d_txn <= '0;
    end else if (accept) begin
      if (!owner && cnt_i_txn != '1) cnt_i_txn <= cnt_i_txn + CNT_W'(1);
      if (owner && cnt_d_txn != '1)  cnt_d_txn <= cnt_d_txn + CNT_W'(1);
    end
  end

  assign rd_acc       = accept & mmu_req_read;
  assign wr_acc       = accept & mmu_req_write;
  assign i_read_done  = rd_acc & ~owner;
  assign i_write_done = wr_acc & ~owner;
  assign d_read_done  = rd_acc & owner;
  assign d_write_done = wr_acc & owner;
  assign i_read_data  = i_read_done ? mmu_read_data : '0;
  assign d_read_data  = d_read_done ? mmu_read_data : '0;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

endmodule
